// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO stack between requesters A and B.
// Optional statistics counters are built when LIFO_ARBITER_STATS_EN is defined.
module lifo_arbiter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_push,
  input  logic          a_pop,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_err,
  output logic [DW-1:0] a_rdata,
  input  logic          b_push,
  input  logic          b_pop,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic          b_err,
  output logic [DW-1:0] b_rdata,
  output logic [DW-1:0] lifo_in,
  output logic          lifo_wn,
  output logic          lifo_rn,
  input  logic [DW-1:0] lifo_out,
  input  logic          lifo_full,
  input  logic          lifo_empty,
  output logic          busy,
  output logic [15:0]   push_cnt,
  output logic [15:0]   pop_cnt,
  output logic [15:0]   rej_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, POP_WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          ptr;      // 0 = A has priority, 1 = B
  logic          gnt;      // latched grant, 0 = A, 1 = B
  logic          op_push;
  logic          op_err;

  logic          a_act, b_act, any_act;
  logic          sel_b, sel_push, sel_rej;
  logic [DW-1:0] sel_data;
  logic          wn_nxt, rn_nxt;

  // A requester still holding its request during its own ack cycle is not
  // a new request, so it is masked to avoid serving it twice.
  assign a_act    = (a_push | a_pop) & ~a_ack;
  assign b_act    = (b_push | b_pop) & ~b_ack;
  assign any_act  = a_act | b_act;
  assign sel_b    = b_act & (~a_act | ptr);
  assign sel_push = sel_b ? b_push : a_push;
  assign sel_data = sel_b ? b_wdata : a_wdata;
  assign sel_rej  = sel_push ? lifo_full : lifo_empty;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    wn_nxt    = 1'b0;
    rn_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (any_act) begin
          if (sel_rej) begin
            state_nxt = RESP;
          end else begin
            state_nxt = ISSUE;
            wn_nxt    = sel_push;
            rn_nxt    = ~sel_push;
          end
        end
      end
      ISSUE:    state_nxt = op_push ? RESP : POP_WAIT;
      POP_WAIT: state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Control: state, grant bookkeeping, stack strobes and handshakes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      gnt     <= 1'b0;
      op_push <= 1'b0;
      op_err  <= 1'b0;
      lifo_wn <= 1'b0;
      lifo_rn <= 1'b0;
      a_ack   <= 1'b0;
      a_err   <= 1'b0;
      b_ack   <= 1'b0;
      b_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      lifo_wn <= wn_nxt;
      lifo_rn <= rn_nxt;
      a_ack   <= (state == RESP) & ~gnt;
      a_err   <= (state == RESP) & ~gnt & op_err;
      b_ack   <= (state == RESP) & gnt;
      b_err   <= (state == RESP) & gnt & op_err;
      if (state == IDLE && any_act) begin
        gnt     <= sel_b;
        op_push <= sel_push;
        op_err  <= sel_rej;
      end
      if (state == RESP) ptr <= ~gnt;
    end
  end

  // Data: push operand toward the stack, popped data back to the grantee
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lifo_in <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (state == IDLE && any_act && sel_push && !sel_rej) lifo_in <= sel_data;
      if (state == POP_WAIT) begin
        if (gnt) b_rdata <= lifo_out;
        else     a_rdata <= lifo_out;
      end
    end
  end

`ifdef LIFO_ARBITER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
      rej_cnt  <= '0;
    end else if (state == RESP) begin
      if (op_err)       rej_cnt  <= sat_inc(rej_cnt);
      else if (op_push) push_cnt <= sat_inc(push_cnt);
      else              pop_cnt  <= sat_inc(pop_cnt);
    end
  end
`else
  assign push_cnt = '0;
  assign pop_cnt  = '0;
  assign rej_cnt  = '0;
`endif

endmodule
